// File: rtl/perm_stream_reorder_if.sv
// Stream bundle for perm_stream_reorder: permutation entries in, data words in, reordered words out.
interface perm_stream_reorder_if #(
  parameter int N = 100,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic          idx_valid;
  logic [IW-1:0] idx_in;
  logic          idx_ready;
  logic          din_valid;
  logic [W-1:0]  din;
  logic          din_ready;
  logic          dout_valid;
  logic [W-1:0]  dout;
  logic          dout_last;
  logic          dout_ready;
  logic          perm_err;

  modport slave (
    input  idx_valid, idx_in, din_valid, din, dout_ready,
    output idx_ready, din_ready, dout_valid, dout, dout_last, perm_err
  );

  modport master (
    output idx_valid, idx_in, din_valid, din, dout_ready,
    input  idx_ready, din_ready, dout_valid, dout, dout_last, perm_err
  );
endinterface

// File: rtl/perm_stream_reorder.sv
// Buffers one frame of N words plus an N-entry permutation, then emits data[perm[k]] for k = 0..N-1.
// Optional duplicate/range checking of the permutation is enabled by defining PERM_CHECK_EN.
module perm_stream_reorder #(
  parameter int N = 100,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  perm_stream_reorder_if.slave   bus
);
  localparam int IW = $clog2(N);
  // Counters need one extra bit so they can reach N itself.
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] NC  = CW'(N);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, FETCH, EMIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idx_cnt, din_cnt, out_cnt;
  logic [IW-1:0] perm_buf [N];
  logic [W-1:0]  data_buf [N];

  logic          idx_hs, din_hs, out_hs;
  logic [CW-1:0] idx_cnt_inc, din_cnt_inc, next_k;
  logic          load_done, out_last;
  logic [IW-1:0] rd_sel, rd_ptr, rd_safe;
  logic [W-1:0]  rd_word;
  logic          idx_in_range;

  assign idx_hs      = bus.idx_valid & bus.idx_ready;
  assign din_hs      = bus.din_valid & bus.din_ready;
  assign out_hs      = bus.dout_valid & bus.dout_ready;
  assign idx_cnt_inc = idx_cnt + CW'(idx_hs);
  assign din_cnt_inc = din_cnt + CW'(din_hs);
  assign load_done   = (idx_cnt_inc == NC) && (din_cnt_inc == NC);
  assign out_last    = (out_cnt == NM1);
  assign next_k      = out_cnt + CW'(1);
  assign idx_in_range = ({1'b0, bus.idx_in} < NC);

  // One read port serves both FETCH (entry 0) and EMIT (entry out_cnt+1).
  assign rd_sel  = (state == EMIT && !out_last) ? next_k[IW-1:0] : '0;
  assign rd_ptr  = perm_buf[rd_sel];
  assign rd_safe = ({1'b0, rd_ptr} < NC) ? rd_ptr : '0;
  assign rd_word = data_buf[rd_safe];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_done) state_nxt = FETCH;
      FETCH:   state_nxt = EMIT;
      EMIT:    if (out_hs && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.idx_ready = (state == LOAD) && (idx_cnt < NC);
    bus.din_ready = (state == LOAD) && (din_cnt < NC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_cnt        <= '0;
      din_cnt        <= '0;
      out_cnt        <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (idx_hs) idx_cnt <= idx_cnt_inc;
          if (din_hs) din_cnt <= din_cnt_inc;
        end
        FETCH: begin
          bus.dout       <= rd_word;
          bus.dout_valid <= 1'b1;
          bus.dout_last  <= (N == 1);
          out_cnt        <= '0;
        end
        EMIT: begin
          if (out_hs) begin
            if (!out_last) begin
              out_cnt       <= next_k;
              bus.dout      <= rd_word;
              bus.dout_last <= (next_k == NM1);
            end else begin
              bus.dout_valid <= 1'b0;
              bus.dout_last  <= 1'b0;
              idx_cnt        <= '0;
              din_cnt        <= '0;
              out_cnt        <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idx_hs) perm_buf[idx_cnt[IW-1:0]] <= bus.idx_in;
    if (din_hs) data_buf[din_cnt[IW-1:0]] <= bus.din;
  end

`ifdef PERM_CHECK_EN
  logic [N-1:0] seen;
  logic         err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen <= '0;
      err  <= 1'b0;
    end else if (state == EMIT && out_hs && out_last) begin
      seen <= '0;
      err  <= 1'b0;
    end else if (idx_hs) begin
      if (!idx_in_range || seen[bus.idx_in]) err <= 1'b1;
      if (idx_in_range) seen[bus.idx_in] <= 1'b1;
    end
  end

  assign bus.perm_err = err;
`else
  logic unused_range;
  assign unused_range = idx_in_range;
  assign bus.perm_err = 1'b0;
`endif
endmodule
